// File: rtl/haze_removal_core_pkg.sv
// Shared constants, pixel types and small helpers for the haze removal pipeline.
package haze_removal_core_pkg;

  localparam int unsigned ONE_Q8       = 256;
  localparam int unsigned T0_NORMAL_Q8 = 26;
  localparam int unsigned T0_LOW_Q8    = 51;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned WIN_N        = 9;
  localparam int unsigned RGB_W        = 3 * PIX_W;
  localparam int unsigned WIN_W        = WIN_N * RGB_W;
  localparam int unsigned CENTRE_IDX   = 4;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_LOW    = 1'b1
  } haze_mode_e;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  function automatic rgb_t win_pixel(input logic [WIN_W-1:0] win, input int unsigned k);
    return win[WIN_W-1-RGB_W*k -: RGB_W];
  endfunction

  function automatic logic [PIX_W-1:0] min3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    logic [PIX_W-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  // Normal mode tracks the running maximum; low-light mode is a 7/8 leaky average with rounding.
  function automatic logic [PIX_W-1:0] light_update(input haze_mode_e md,
                                                    input logic [PIX_W-1:0] prev,
                                                    input logic [PIX_W-1:0] m);
    logic [PIX_W+2:0] acc;
    acc = '0;
    if (md == MODE_LOW) begin
      acc = ({3'b000, prev} << 3) - {3'b000, prev} + {3'b000, m} + (PIX_W+3)'(4);
      return acc[PIX_W+2:3];
    end
    return (m > prev) ? m : prev;
  endfunction

endpackage

// File: rtl/haze_removal_core_q8_divider.sv
// Combinational unsigned restoring divider; quotient saturates to all-ones when it exceeds W_Q bits.
module q8_divider #(
  parameter int unsigned W_N = 16,
  parameter int unsigned W_D = 8,
  parameter int unsigned W_Q = 8
) (
  input  logic [W_N-1:0] num,
  input  logic [W_D-1:0] den,
  output logic [W_Q-1:0] quo
);

  logic [W_N-1:0] q_full;
  logic [W_D:0]   rem;

  // A zero divisor yields an all-ones quotient, which the saturation then maps to '1.
  always_comb begin
    q_full = '0;
    rem    = '0;
    for (int unsigned k = 0; k < W_N; k++) begin
      rem = {rem[W_D-1:0], num[W_N-1-k]};
      if (rem >= {1'b0, den}) begin
        rem               = rem - {1'b0, den};
        q_full[W_N-1-k]   = 1'b1;
      end
    end
    quo = (|q_full[W_N-1:W_Q]) ? '1 : q_full[W_Q-1:0];
  end

endmodule

// File: rtl/haze_removal_core.sv
// Four-stage dark-channel haze removal: window min, atmospheric light, transmission, restore.
module haze_removal_core #(
  parameter int unsigned W_FRAC    = 8,
  parameter int unsigned T0_NORMAL = haze_removal_core_pkg::T0_NORMAL_Q8,
  parameter int unsigned T0_LOW    = haze_removal_core_pkg::T0_LOW_Q8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         load,
  input  logic [215:0] rgb_window,
  input  logic [4:0]   w,
  input  logic [7:0]   a_prev_r,
  input  logic [7:0]   a_prev_g,
  input  logic [7:0]   a_prev_b,
  output logic [7:0]   a_glob_r,
  output logic [7:0]   a_glob_g,
  output logic [7:0]   a_glob_b,
  output logic [7:0]   o_r,
  output logic [7:0]   o_g,
  output logic [7:0]   o_b,
  output logic [11:0]  t_inv,
  output logic         ed_bit
);
  import haze_removal_core_pkg::*;

  localparam int unsigned T_W     = W_FRAC + 1;
  localparam int unsigned RAT_NW  = PIX_W + W_FRAC;
  localparam int unsigned REC_NW  = 2 * W_FRAC + 1;
  localparam int unsigned TINV_W  = 12;
  localparam int unsigned PROD_W  = 22;
  localparam int unsigned WR_W    = 13;
  localparam logic [T_W-1:0]    ONE_T     = T_W'(1) << W_FRAC;
  localparam logic [REC_NW-1:0] RECIP_NUM = REC_NW'(1) << (2 * W_FRAC);

  // Signed restore: A + floor((I - A) * t_inv / 2^W_FRAC), clamped to pixel range.
  function automatic logic [PIX_W-1:0] restore(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] i,
                                               input logic [TINV_W-1:0] ti);
    logic signed [PROD_W-1:0] d, t, p, s;
    d = $signed({{(PROD_W-PIX_W){1'b0}}, i}) - $signed({{(PROD_W-PIX_W){1'b0}}, a});
    t = $signed({{(PROD_W-TINV_W){1'b0}}, ti});
    p = (d * t) >>> W_FRAC;
    s = p + $signed({{(PROD_W-PIX_W){1'b0}}, a});
    if (s < 22'sd0)
      return '0;
    else if (s > 22'sd255)
      return '1;
    return s[PIX_W-1:0];
  endfunction

  haze_mode_e mode_e;
  assign mode_e = haze_mode_e'(mode);

  // S0: window register
  logic [WIN_W-1:0] win_q;

  always_ff @(posedge clk) begin
    if (rst)
      win_q <= '0;
    else if (load)
      win_q <= rgb_window;
  end

  // S1: per-channel minima and dark channel
  logic [PIX_W-1:0] mn_r, mn_g, mn_b;
  rgb_t             px;

  always_comb begin
    px   = '0;
    mn_r = '1;
    mn_g = '1;
    mn_b = '1;
    for (int unsigned k = 0; k < WIN_N; k++) begin
      px = win_pixel(win_q, k);
      if (px.r < mn_r) mn_r = px.r;
      if (px.g < mn_g) mn_g = px.g;
      if (px.b < mn_b) mn_b = px.b;
    end
  end

  rgb_t             s1_min, s1_ctr;
  logic [PIX_W-1:0] s1_dark;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_min  <= '0;
      s1_ctr  <= '0;
      s1_dark <= '0;
    end else begin
      s1_min  <= '{r: mn_r, g: mn_g, b: mn_b};
      s1_ctr  <= win_pixel(win_q, CENTRE_IDX);
      s1_dark <= min3(mn_r, mn_g, mn_b);
    end
  end

  // S2: atmospheric light
  rgb_t             a_q, s2_ctr;
  logic [PIX_W-1:0] s2_dark;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      s2_ctr  <= '0;
      s2_dark <= '0;
    end else begin
      a_q.r   <= light_update(mode_e, a_prev_r, s1_min.r);
      a_q.g   <= light_update(mode_e, a_prev_g, s1_min.g);
      a_q.b   <= light_update(mode_e, a_prev_b, s1_min.b);
      s2_ctr  <= s2_ctr_next();
      s2_dark <= s1_dark;
    end
  end

  function automatic rgb_t s2_ctr_next();
    return s1_ctr;
  endfunction

  assign a_glob_r = a_q.r;
  assign a_glob_g = a_q.g;
  assign a_glob_b = a_q.b;

  // S3: transmission with floor clamp, then its reciprocal
  logic [PIX_W-1:0]  amin, ratio;
  logic [T_W-1:0]    t_raw, t0, t_fl;
  logic              clamp;
  logic [TINV_W-1:0] tinv_next;

  always_comb begin
    amin  = min3(a_q.r, a_q.g, a_q.b);
    if (amin == '0)
      amin = PIX_W'(1);
    t_raw = ONE_T - T_W'((WR_W'(w) * WR_W'(ratio)) >> 5);
    t0    = (mode_e == MODE_LOW) ? T_W'(T0_LOW) : T_W'(T0_NORMAL);
    clamp = (t_raw < t0);
    t_fl  = clamp ? t0 : t_raw;
  end

  // Quotient saturation to 8 bits performs the min(...,255) on the ratio.
  q8_divider #(
    .W_N (RAT_NW),
    .W_D (PIX_W),
    .W_Q (PIX_W)
  ) u_ratio_div (
    .num ({s2_dark, {W_FRAC{1'b0}}}),
    .den (amin),
    .quo (ratio)
  );

  q8_divider #(
    .W_N (REC_NW),
    .W_D (T_W),
    .W_Q (TINV_W)
  ) u_recip_div (
    .num (RECIP_NUM),
    .den (t_fl),
    .quo (tinv_next)
  );

  rgb_t s3_a, s3_ctr;

  always_ff @(posedge clk) begin
    if (rst) begin
      t_inv  <= '0;
      ed_bit <= 1'b0;
      s3_a   <= '0;
      s3_ctr <= '0;
    end else begin
      t_inv  <= tinv_next;
      ed_bit <= clamp;
      s3_a   <= a_q;
      s3_ctr <= s2_ctr;
    end
  end

  // S4: restored centre pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r <= '0;
      o_g <= '0;
      o_b <= '0;
    end else begin
      o_r <= restore(s3_a.r, s3_ctr.r, t_inv);
      o_g <= restore(s3_a.g, s3_ctr.g, t_inv);
      o_b <= restore(s3_a.b, s3_ctr.b, t_inv);
    end
  end

endmodule

// File: tb/tb_haze_removal_core.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with a due cycle; a monitor compares.
module tb_haze_removal_core;

  logic         clk = 1'b0;
  logic         rst, mode, load;
  logic [215:0] rgb_window;
  logic [4:0]   w;
  logic [7:0]   a_prev_r, a_prev_g, a_prev_b;
  logic [7:0]   a_glob_r, a_glob_g, a_glob_b;
  logic [7:0]   o_r, o_g, o_b;
  logic [11:0]  t_inv;
  logic         ed_bit;

  haze_removal_core #(
    .W_FRAC    (8),
    .T0_NORMAL (26),
    .T0_LOW    (51)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .load       (load),
    .rgb_window (rgb_window),
    .w          (w),
    .a_prev_r   (a_prev_r),
    .a_prev_g   (a_prev_g),
    .a_prev_b   (a_prev_b),
    .a_glob_r   (a_glob_r),
    .a_glob_g   (a_glob_g),
    .a_glob_b   (a_glob_b),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b),
    .t_inv      (t_inv),
    .ed_bit     (ed_bit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [23:0] val;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  exp_t        e;
  logic [23:0] act;

  // kind 0: a_glob, kind 1: {ed_bit, t_inv}, kind 2: o
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      case (e.kind)
        0:       act = {a_glob_r, a_glob_g, a_glob_b};
        1:       act = {11'b0, ed_bit, t_inv};
        default: act = {o_r, o_g, o_b};
      endcase
      if (e.due < cyc) begin
        failures++;
        $display("FAIL %s: slot missed (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if (act !== e.val) begin
        failures++;
        $display("FAIL %s: cycle %0d got 0x%06h expected 0x%06h", e.name, cyc, act, e.val);
      end
    end
  end

  function automatic logic [215:0] uni(input logic [23:0] p);
    logic [215:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[215-24*k -: 24] = p;
    return r;
  endfunction

  function automatic logic [215:0] set_px(input logic [215:0] win, input int k, input logic [23:0] p);
    logic [215:0] r;
    r = win;
    r[215-24*k -: 24] = p;
    return r;
  endfunction

  task automatic push(input int due, input int kind, input logic [23:0] v, input string nm);
    exp_t x;
    x.due  = due;
    x.kind = kind;
    x.val  = v;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic capture(input logic md, input logic [4:0] ww, input logic [23:0] ap,
                         input logic [215:0] win, input logic [23:0] ea,
                         input logic [11:0] eti, input logic eed, input logic [23:0] eo,
                         input string nm);
    int n;
    @(posedge clk); #1;
    mode = md;
    w    = ww;
    {a_prev_r, a_prev_g, a_prev_b} = ap;
    rgb_window = win;
    load = 1'b1;
    n = cyc + 1;
    push(n + 2, 0, ea, {nm, ".a_glob"});
    push(n + 3, 1, {11'b0, eed, eti}, {nm, ".t_inv_ed"});
    push(n + 4, 2, eo, {nm, ".o"});
    @(posedge clk); #1;
    load = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst  = 1'b1;
    load = 1'b1;
    mode = 1'b1;
    w    = 5'd31;
    rgb_window = uni(24'h7F3A11);
    {a_prev_r, a_prev_g, a_prev_b} = 24'hC8C8C8;
    for (int c = 1; c <= 2; c++) begin
      push(c, 0, 24'h0, "reset.a_glob");
      push(c, 1, 24'h0, "reset.t_inv_ed");
      push(c, 2, 24'h0, "reset.o");
    end
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    load = 1'b0;
    mode = 1'b0;
    w    = 5'd0;
    rgb_window = '0;
    {a_prev_r, a_prev_g, a_prev_b} = 24'h0;
    push(6, 0, 24'h0, "release.a_glob");
    push(6, 1, {11'b0, 1'b0, 12'd256}, "release.t_inv_ed");
    push(6, 2, 24'h0, "release.o");
    repeat (5) @(posedge clk);

    capture(1'b0, 5'd23, 24'hC8C8C8, uni(24'h646464),
            24'hC8C8C8, 12'd399, 1'b0, 24'h2C2C2C, "uniform");
    capture(1'b0, 5'd31, 24'hFAFAFA, uni(24'hFAFAFA),
            24'hFAFAFA, 12'd2520, 1'b1, 24'hFAFAFA, "dense_m0");
    capture(1'b1, 5'd31, 24'hFAFAFA, uni(24'hFAFAFA),
            24'hFAFAFA, 12'd1285, 1'b1, 24'hFAFAFA, "dense_m1");
    capture(1'b0, 5'd8, 24'hC8C8C8, set_px(uni(24'hF0F0F0), 0, {8'd220, 8'd210, 8'd230}),
            {8'd220, 8'd210, 8'd230}, 12'd339, 1'b0, {8'd246, 8'd249, 8'd243}, "light_m0");
    capture(1'b1, 5'd16, 24'hC8C8C8, uni({8'd120, 8'd120, 8'd120}),
            {8'd190, 8'd190, 8'd190}, 12'd372, 1'b0, {8'd88, 8'd88, 8'd88}, "light_m1");

    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      rgb_window = set_px(uni({8'(i * 40 + 3), 8'(255 - i * 30), 8'(i * 11)}), 4, 24'hFF00FF);
      load = 1'b0;
      push(cyc + 4, 0, {8'd190, 8'd190, 8'd190}, "hold.a_glob");
      push(cyc + 4, 1, {11'b0, 1'b0, 12'd372}, "hold.t_inv_ed");
      push(cyc + 4, 2, {8'd88, 8'd88, 8'd88}, "hold.o");
    end
    repeat (5) @(posedge clk);

    capture(1'b0, 5'd31, 24'h141414, set_px(uni(24'h0A0A0A), 4, 24'hFFFFFF),
            24'h141414, 12'd496, 1'b0, 24'hFFFFFF, "saturate");
    capture(1'b0, 5'd31, 24'h000000, uni(24'h000000),
            24'h000000, 12'd256, 1'b0, 24'h000000, "zero_guard");

    guard = 0;
    while (sb.size() > 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never compared", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
